// File: rtl/fader_pkg.sv
// Shared types and helpers for the RGB hue fader: operating modes, the
// six-segment hue wheel and the per-segment duty profile.
package fader_pkg;

    localparam int unsigned NUM_SEGS = 6;
    localparam int unsigned SEG_W    = 3;

    typedef enum logic [1:0] {
        MODE_HUE     = 2'b00,
        MODE_BREATHE = 2'b01,
        MODE_HOLD    = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        PROF_RISE = 2'd0,
        PROF_FULL = 2'd1,
        PROF_FALL = 2'd2,
        PROF_ZERO = 2'd3
    } prof_e;

    // Raw mode pins; the unused code 11 behaves as HOLD.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b00:   return MODE_HUE;
            2'b01:   return MODE_BREATHE;
            default: return MODE_HOLD;
        endcase
    endfunction

    function automatic prof_e seg_profile(input logic [SEG_W-1:0] seg);
        case (seg)
            3'd0:       return PROF_RISE;
            3'd1, 3'd2: return PROF_FULL;
            3'd3:       return PROF_FALL;
            default:    return PROF_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/fader_pwm_channel.sv
// One PWM channel: duty latched at the period wrap, active-low registered pin.
// Optional FADER_BRIGHTNESS_EN scales the latched duty by i_brightness/256.
module fader_pwm_channel #(
    parameter int unsigned c_DUTY_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wrap,
    input  logic [c_DUTY_W-1:0] i_cnt,
    input  logic [c_DUTY_W-1:0] i_duty,
`ifdef FADER_BRIGHTNESS_EN
    input  logic [7:0]          i_brightness,
`endif
    output logic                o_pwm
);

    logic [c_DUTY_W-1:0] duty_q, duty_d;
    logic [c_DUTY_W-1:0] duty_next_c;
    logic                pwm_q, pwm_d;

`ifdef FADER_BRIGHTNESS_EN
    localparam int unsigned PROD_W = c_DUTY_W + 8;
    assign duty_next_c = c_DUTY_W'((PROD_W'(i_duty) * PROD_W'(i_brightness)) >> 8);
`else
    assign duty_next_c = i_duty;
`endif

    // Duty only changes at the wrap so a period is never split between two values.
    always_comb begin
        duty_d = duty_q;
        if (i_wrap) begin
            duty_d = duty_next_c;
        end
        pwm_d = !(i_cnt < duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pwm_q  <= 1'b1;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign o_pwm = pwm_q;

endmodule

// File: rtl/rgb_hue_fader.sv
// Multi-channel LED fader: hue wheel, breathe or hold, on a shared PWM counter.
// Define FADER_BRIGHTNESS_EN to add the i_brightness scaling input.
module rgb_hue_fader
    import fader_pkg::*;
#(
    parameter int unsigned c_CHANNELS     = 3,
    parameter int unsigned c_PWM_INTERVAL = 1200,
    parameter int unsigned c_SEG_STEPS    = 200,
    parameter int unsigned c_STEP_CYCLES  = 10000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_mode,
`ifdef FADER_BRIGHTNESS_EN
    input  logic [7:0]            i_brightness,
`endif
    output logic [c_CHANNELS-1:0] o_pwm,
    output logic                  o_period_start
);

    localparam int unsigned DUTY_W = $clog2(c_PWM_INTERVAL + 1);
    localparam int unsigned CNT_W  = (c_PWM_INTERVAL > 1) ? $clog2(c_PWM_INTERVAL) : 1;
    localparam int unsigned TMR_W  = (c_STEP_CYCLES > 1) ? $clog2(c_STEP_CYCLES) : 1;
    localparam int unsigned STEP_W = (c_SEG_STEPS > 1) ? $clog2(c_SEG_STEPS) : 1;
    localparam int unsigned INC    = c_PWM_INTERVAL / c_SEG_STEPS;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              period_start_q, period_start_d;
    mode_e             mode_q, mode_d;
    logic              breathe_q, breathe_d;
    logic              fall_q, fall_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic              wrap_c, tick_c;
    mode_e             mode_in_c;
    logic [DUTY_W-1:0] ramp_up_c, ramp_dn_c;

    assign wrap_c    = (cnt_q == CNT_W'(c_PWM_INTERVAL - 1));
    assign tick_c    = (tmr_q == TMR_W'(c_STEP_CYCLES - 1));
    assign mode_in_c = decode_mode(i_mode);
    assign ramp_up_c = DUTY_W'(step_q) * DUTY_W'(INC);
    assign ramp_dn_c = DUTY_W'(c_PWM_INTERVAL) - ramp_up_c;

    // Counters and sequencer; entering HOLD freezes the position so duties stay put.
    always_comb begin
        cnt_d          = wrap_c ? '0 : cnt_q + CNT_W'(1);
        tmr_d          = tick_c ? '0 : tmr_q + TMR_W'(1);
        period_start_d = wrap_c;
        mode_d         = mode_q;
        breathe_d      = breathe_q;
        fall_d         = fall_q;
        seg_d          = seg_q;
        step_d         = step_q;
        if (tick_c) begin
            if (mode_in_c != mode_q) begin
                mode_d = mode_in_c;
                if (mode_in_c != MODE_HOLD) begin
                    step_d    = '0;
                    fall_d    = 1'b0;
                    breathe_d = (mode_in_c == MODE_BREATHE);
                    if (mode_in_c == MODE_HUE) begin
                        seg_d = '0;
                    end
                end
            end else if (mode_q != MODE_HOLD) begin
                if (step_q == STEP_W'(c_SEG_STEPS - 1)) begin
                    step_d = '0;
                    if (breathe_q) begin
                        fall_d = !fall_q;
                    end else begin
                        seg_d = (seg_q == SEG_W'(NUM_SEGS - 1)) ? '0 : seg_q + SEG_W'(1);
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            tmr_q          <= '0;
            period_start_q <= 1'b0;
            mode_q         <= MODE_HUE;
            breathe_q      <= 1'b0;
            fall_q         <= 1'b0;
            seg_q          <= '0;
            step_q         <= '0;
        end else begin
            cnt_q          <= cnt_d;
            tmr_q          <= tmr_d;
            period_start_q <= period_start_d;
            mode_q         <= mode_d;
            breathe_q      <= breathe_d;
            fall_q         <= fall_d;
            seg_q          <= seg_d;
            step_q         <= step_d;
        end
    end

    assign o_period_start = period_start_q;

    // Channel k sits 2k segments behind channel 0 on the hue wheel.
    for (genvar k = 0; k < int'(c_CHANNELS); k++) begin : g_ch
        localparam int unsigned OFF = (NUM_SEGS - (2 * k) % NUM_SEGS) % NUM_SEGS;

        logic [SEG_W:0]    seg_sum_c;
        logic [SEG_W-1:0]  ch_seg_c;
        logic [DUTY_W-1:0] duty_c;

        assign seg_sum_c = {1'b0, seg_q} + (SEG_W + 1)'(OFF);
        assign ch_seg_c  = (seg_sum_c >= (SEG_W + 1)'(NUM_SEGS))
                         ? SEG_W'(seg_sum_c - (SEG_W + 1)'(NUM_SEGS))
                         : SEG_W'(seg_sum_c);

        always_comb begin
            duty_c = '0;
            if (breathe_q) begin
                duty_c = fall_q ? ramp_dn_c : ramp_up_c;
            end else begin
                case (seg_profile(ch_seg_c))
                    PROF_RISE: duty_c = ramp_up_c;
                    PROF_FULL: duty_c = DUTY_W'(c_PWM_INTERVAL);
                    PROF_FALL: duty_c = ramp_dn_c;
                    default:   duty_c = '0;
                endcase
            end
        end

        fader_pwm_channel #(
            .c_DUTY_W (DUTY_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_wrap       (wrap_c),
            .i_cnt        (DUTY_W'(cnt_q)),
            .i_duty       (duty_c),
`ifdef FADER_BRIGHTNESS_EN
            .i_brightness (i_brightness),
`endif
            .o_pwm        (o_pwm[k])
        );
    end

endmodule
